cmem_resp: RTL and testbench

- External-bus responder for the shared cache memory's line-refill port.
- Accepts a block read (b_addr_c, b_rd_c) from the cache and issues one burst request to backing memory.
- Assembles BEATS = LINE_W/BEAT_W beats into a full line and returns it with a one-cycle b_dv_c pulse.
- Optionally snoops external writes and drives the cache invalidation port (inv, b_inv_addr_c).

---
 rtl/cmem_resp_pkg.sv | 19 +
 rtl/cmem_resp_lineasm.sv | 43 ++++
 rtl/cmem_resp.sv | 130 +++++++++++++
 tb/tb_cmem_resp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmem_resp_pkg.sv
// Shared configuration for the cache-memory refill responder.
// Line/beat geometry and the responder FSM state encoding.
package cmem_resp_pkg;

  localparam int CMEM_LINE     = 512;
  localparam int CMEM_BLK_LEN  = 58;
  localparam int CMEM_BEAT_W   = 64;
  localparam int CMEM_BEATS    = CMEM_LINE / CMEM_BEAT_W;
  localparam int CMEM_OFFS_LEN = $clog2(CMEM_LINE / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/cmem_resp_lineasm.sv
// Beat counter and line assembly register for cache line refills.
// Each load writes one beat at the current position; done marks the final beat.
module cmem_resp_lineasm
  import cmem_resp_pkg::*;
#(
  parameter int LINE_W = CMEM_LINE,
  parameter int BEAT_W = CMEM_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [BEAT_W-1:0] beat,
  output logic [LINE_W-1:0] line,
  output logic              done
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt;

  assign done = load && (cnt == LAST);

  // The counter returns to zero on the final beat so a refetch starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      line <= '0;
    end else begin
      if (clear || done) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        line[int'(cnt) * BEAT_W +: BEAT_W] <= beat;
      end
    end
  end

endmodule

// File: rtl/cmem_resp.sv
// Line-refill responder: one burst per cache block read, line returned with a b_dv_c pulse.
// Define CMEM_RESP_INV_EN to enable snoop invalidation and stale-line refetch.
module cmem_resp
  import cmem_resp_pkg::*;
#(
  parameter int LINE_W  = CMEM_LINE,
  parameter int BLK_LEN = CMEM_BLK_LEN,
  parameter int BEAT_W  = CMEM_BEAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] b_addr_c,
  input  logic               b_rd_c,
  output logic [LINE_W-1:0]  b_rdata_c,
  output logic               b_dv_c,
  output logic [63:0]        m_addr,
  output logic               m_req,
  input  logic               m_gnt,
  input  logic [BEAT_W-1:0]  m_rdata,
  input  logic               m_rvalid,
  input  logic [63:0]        snp_addr,
  input  logic               snp_wr,
  output logic [BLK_LEN-1:0] b_inv_addr_c,
  output logic               inv
);

  localparam int OFFS_LEN = 64 - BLK_LEN;

  state_t state, state_nx;
  logic   abort_q;
  logic   load;
  logic   done;
  logic   refetch;

  assign load = (state == S_DATA) && m_rvalid;

  cmem_resp_lineasm #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_lineasm (
    .clk   (clk),
    .rst   (rst),
    .clear (state == S_IDLE),
    .load  (load),
    .beat  (m_rdata),
    .line  (b_rdata_c),
    .done  (done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (b_rd_c) state_nx = S_REQ;
      S_REQ:  if (m_gnt) state_nx = S_DATA;
      S_DATA: begin
        // A requester that let go mid-burst gets no response; the beats are still drained.
        if (done) begin
          if (abort_q || !b_rd_c) state_nx = S_IDLE;
          else if (refetch)       state_nx = S_REQ;
          else                    state_nx = S_RESP;
        end
      end
      S_RESP: state_nx = S_GAP;
      S_GAP:  if (!b_rd_c) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      m_req   <= 1'b0;
      b_dv_c  <= 1'b0;
      m_addr  <= '0;
      abort_q <= 1'b0;
    end else begin
      state  <= state_nx;
      m_req  <= (state_nx == S_REQ);
      b_dv_c <= (state_nx == S_RESP);
      if (state == S_IDLE && b_rd_c) begin
        m_addr <= {b_addr_c, {OFFS_LEN{1'b0}}};
      end
      if (state == S_IDLE) begin
        abort_q <= 1'b0;
      end else if ((state == S_REQ || state == S_DATA) && !b_rd_c) begin
        abort_q <= 1'b1;
      end
    end
  end

`ifdef CMEM_RESP_INV_EN
  logic               stale_q;
  logic               stale_set;
  logic [BLK_LEN-1:0] snp_blk;
  logic               unused_snp;

  assign snp_blk    = snp_addr[63 -: BLK_LEN];
  assign unused_snp = ^snp_addr[OFFS_LEN-1:0];
  assign stale_set  = snp_wr && (snp_blk == m_addr[63 -: BLK_LEN]) &&
                      (state == S_REQ || state == S_DATA);
  assign refetch    = stale_q || stale_set;

  // A snoop landing on the final beat is folded into this burst's refetch decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv          <= 1'b0;
      b_inv_addr_c <= '0;
      stale_q      <= 1'b0;
    end else begin
      inv <= snp_wr;
      if (snp_wr) begin
        b_inv_addr_c <= snp_blk;
      end
      if (state == S_IDLE || done) begin
        stale_q <= 1'b0;
      end else if (stale_set) begin
        stale_q <= 1'b1;
      end
    end
  end
`else
  logic unused_snp;

  assign unused_snp   = ^{snp_wr, snp_addr};
  assign refetch      = 1'b0;
  assign inv          = 1'b0;
  assign b_inv_addr_c = '0;
`endif

endmodule

// File: tb/tb_cmem_resp.sv
// Self-checking bench for cmem_resp: directed and randomized refills against a cycle-schedule model.
// The schedule model derives grant, beat and b_dv_c cycles arithmetically from the protocol rules.
module tb_cmem_resp;

  localparam int LINE_W  = 512;
  localparam int BLK_LEN = 58;
  localparam int BEAT_W  = 64;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int OFFS    = 6;
`ifdef CMEM_RESP_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [BLK_LEN-1:0] b_addr_c;
  logic               b_rd_c;
  logic [LINE_W-1:0]  b_rdata_c;
  logic               b_dv_c;
  logic [63:0]        m_addr;
  logic               m_req;
  logic               m_gnt;
  logic [BEAT_W-1:0]  m_rdata;
  logic               m_rvalid;
  logic [63:0]        snp_addr;
  logic               snp_wr;
  logic [BLK_LEN-1:0] b_inv_addr_c;
  logic               inv;

  int checks = 0;
  int errors = 0;

  logic [BEAT_W-1:0] beat_q [2][BEATS];
  int                gap_len[BEATS];

  cmem_resp dut (
    .clk          (clk),
    .rst          (rst),
    .b_addr_c     (b_addr_c),
    .b_rd_c       (b_rd_c),
    .b_rdata_c    (b_rdata_c),
    .b_dv_c       (b_dv_c),
    .m_addr       (m_addr),
    .m_req        (m_req),
    .m_gnt        (m_gnt),
    .m_rdata      (m_rdata),
    .m_rvalid     (m_rvalid),
    .snp_addr     (snp_addr),
    .snp_wr       (snp_wr),
    .b_inv_addr_c (b_inv_addr_c),
    .inv          (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomBeats();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < BEATS; i++)
        beat_q[b][i] = {$urandom, $urandom};
  endtask

  task automatic clearGaps();
    for (int i = 0; i < BEATS; i++) gap_len[i] = 0;
  endtask

  // One complete request: drives the cache side and backing memory from a precomputed schedule.
  task automatic applyStimulus(input logic [BLK_LEN-1:0] addr, input int gnt_dly,
                               input int hold_extra, input int drop_after,
                               input int snp_cyc, input logic [63:0] snp_a);
    int beat_cyc[2][BEATS];
    int gnt_cyc[2];
    int c, last0, last, dv_cyc, rd_last, end_cyc;
    bit stale, dropped, got, inv_exp;
    logic [LINE_W-1:0] exp_line;
    logic [BEAT_W-1:0] d;

    dropped    = (drop_after >= 0);
    gnt_cyc[0] = 1 + gnt_dly;
    c          = gnt_cyc[0] + 1;
    for (int i = 0; i < BEATS; i++) begin
      beat_cyc[0][i] = c;
      c += 1 + gap_len[i];
    end
    last0 = beat_cyc[0][BEATS-1];
    stale = INV_EN && !dropped && snp_cyc >= 1 && snp_cyc <= last0 &&
            ((snp_a >> OFFS) == 64'(addr));
    gnt_cyc[1] = stale ? last0 + 1 : -1;
    for (int i = 0; i < BEATS; i++) beat_cyc[1][i] = stale ? last0 + 2 + i : -1;
    last    = stale ? beat_cyc[1][BEATS-1] : last0;
    dv_cyc  = dropped ? -1 : last + 1;
    rd_last = dropped ? beat_cyc[0][drop_after] : dv_cyc + hold_extra;
    end_cyc = dropped ? last + 2 : dv_cyc + hold_extra + 1;
    for (int i = 0; i < BEATS; i++) exp_line[i*BEAT_W +: BEAT_W] = beat_q[stale ? 1 : 0][i];

    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      @(posedge clk);
      #1;
      inv_exp = INV_EN && snp_cyc >= 0 && cyc == snp_cyc + 1;
      checkOutput($sformatf("m_req@%0d", cyc), LINE_W'(m_req),
                  LINE_W'((cyc >= 1 && cyc <= gnt_cyc[0]) || cyc == gnt_cyc[1]));
      checkOutput($sformatf("b_dv_c@%0d", cyc), LINE_W'(b_dv_c), LINE_W'(cyc == dv_cyc));
      checkOutput($sformatf("inv@%0d", cyc), LINE_W'(inv), LINE_W'(inv_exp));
      if (cyc == 1)
        checkOutput("m_addr", LINE_W'(m_addr), LINE_W'(64'(addr) << OFFS));
      if (cyc == dv_cyc)
        checkOutput("line", b_rdata_c, exp_line);
      if (snp_cyc >= 0 && cyc == snp_cyc + 1)
        checkOutput("b_inv_addr_c", LINE_W'(b_inv_addr_c),
                    INV_EN ? LINE_W'(snp_a >> OFFS) : '0);

      b_addr_c = addr;
      b_rd_c   = (cyc <= rd_last);
      m_gnt    = (cyc == gnt_cyc[0]) || (cyc == gnt_cyc[1]);
      got      = 1'b0;
      d        = {$urandom, $urandom};
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < BEATS; i++)
          if (cyc == beat_cyc[b][i]) begin
            got = 1'b1;
            d   = beat_q[b][i];
          end
      // Junk beats while still waiting for the grant must be ignored.
      m_rvalid = got || (cyc >= 1 && cyc < gnt_cyc[0]);
      m_rdata  = d;
      snp_wr   = (cyc == snp_cyc);
      snp_addr = snp_wr ? snp_a : {$urandom, $urandom};
    end
  endtask

  initial begin
    logic [BLK_LEN-1:0] addr;
    int drop, snp;
    logic [63:0] sa;

    rst = 1'b1; b_addr_c = '0; b_rd_c = 1'b0; m_gnt = 1'b0; m_rdata = '0;
    m_rvalid = 1'b0; snp_addr = '0; snp_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_req", LINE_W'(m_req), '0);
    checkOutput("rst_b_dv_c", LINE_W'(b_dv_c), '0);
    checkOutput("rst_m_addr", LINE_W'(m_addr), '0);
    checkOutput("rst_line", b_rdata_c, '0);
    checkOutput("rst_inv", LINE_W'(inv), '0);
    @(negedge clk) rst = 1'b0;

    $display("[TB] zero-wait fill of block 1");
    clearGaps();
    for (int i = 0; i < BEATS; i++) beat_q[0][i] = 64'(i);
    applyStimulus(58'h1, 0, 0, -1, -1, '0);

    $display("[TB] delayed grant plus one-cycle beat gap");
    gap_len[3] = 1;
    applyStimulus(58'h1, 3, 0, -1, -1, '0);

    $display("[TB] b_rd_c held after b_dv_c, then re-raised");
    clearGaps();
    randomBeats();
    applyStimulus(58'h2A5, 0, 4, -1, -1, '0);
    randomBeats();
    applyStimulus(58'h3_0000_0001, 1, 0, -1, -1, '0);

    $display("[TB] b_rd_c dropped after beat 2, then a normal fill");
    randomBeats();
    applyStimulus(58'h77, 0, 0, 2, -1, '0);
    randomBeats();
    applyStimulus(58'h78, 0, 0, -1, -1, '0);

    $display("[TB] snoop on the block being filled, and on another block");
    randomBeats();
    applyStimulus(58'h1, 0, 0, -1, 4, 64'h48);
    randomBeats();
    applyStimulus(58'h5, 2, 0, -1, 2, 64'h1000);
    randomBeats();
    applyStimulus(58'h9, 0, 0, -1, 9, 64'h240);

    $display("[TB] asynchronous reset mid-burst");
    randomBeats();
    @(posedge clk); #1; b_addr_c = 58'h123; b_rd_c = 1'b1;
    @(posedge clk); #1; m_gnt = 1'b1;
    @(posedge clk); #1; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = beat_q[0][0];
    @(posedge clk); #1; m_rdata = beat_q[0][1];
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_m_req", LINE_W'(m_req), '0);
    checkOutput("arst_b_dv_c", LINE_W'(b_dv_c), '0);
    checkOutput("arst_m_addr", LINE_W'(m_addr), '0);
    checkOutput("arst_line", b_rdata_c, '0);
    checkOutput("arst_inv", LINE_W'(inv), '0);
    checkOutput("arst_inv_addr", LINE_W'(b_inv_addr_c), '0);
    m_rvalid = 1'b0; b_rd_c = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    randomBeats();
    applyStimulus(58'h456, 0, 0, -1, -1, '0);

    $display("[TB] randomized fills");
    for (int n = 0; n < 10; n++) begin
      addr = BLK_LEN'({$urandom, $urandom});
      randomBeats();
      for (int i = 0; i < BEATS; i++)
        gap_len[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 2)) : -1;
      snp  = -1;
      sa   = '0;
      if (drop < 0 && $urandom_range(0, 1) == 1) begin
        snp = int'($urandom_range(1, 6));
        sa  = ($urandom_range(0, 1) == 1) ? ((64'(addr) << OFFS) | 64'($urandom_range(0, 63)))
                                          : {$urandom, $urandom};
      end
      applyStimulus(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), drop, snp, sa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
